// File: rtl/coin_sprite_fetch.sv
// Coin-spin sprite reader: beam/box compare, ROM addressing, colour keying and spin/collect animation.
// Optional build macro COIN_FLASH_EN inverts opaque colours on odd collect ticks.
module coin_sprite_fetch #(
    parameter int          SPR_W         = 20,
    parameter int          SPR_H         = 20,
    parameter int          FRAME_DIV     = 8,
    parameter int          COLLECT_TICKS = 16,
    parameter int          RISE_STEP     = 2,
    parameter logic [23:0] TRANS_KEY     = 24'h800080
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collect,
    input  logic [9:0]  coin_x,
    input  logic [9:0]  coin_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [23:0] rom_color,
    output logic [8:0]  read_address,
    output logic [1:0]  frame_sel,
    output logic [23:0] pixel_color,
    output logic        pixel_valid,
    output logic        busy,
    output logic        collected_done
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int CNT_W = (COLLECT_TICKS > 1) ? $clog2(COLLECT_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLLECT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SPIN, COLLECT} state_t;

    state_t           state;
    logic [DIV_W-1:0] divider;
    logic [CNT_W-1:0] tick_count;
    logic [9:0]       rise;
    logic             in_box_q;

    logic [9:0]  top;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        in_box;
    logic [8:0]  addr_next;
    logic        finishing;
    logic        opaque;
    logic [23:0] shade;

    // A coin that has risen above the screen top is dropped rather than wrapped to the bottom.
    always_comb begin
        top       = coin_y - rise;
        col       = DrawX - coin_x;
        row       = DrawY - top;
        in_box    = busy && (coin_y >= rise)
                    && (DrawX >= coin_x) && (col < 10'(SPR_W))
                    && (DrawY >= top)    && (row < 10'(SPR_H));
        addr_next = in_box ? 9'(row * 10'(SPR_W) + col) : 9'd0;
        finishing = (state == COLLECT) && frame_tick && (tick_count == CNT_LAST);
        opaque    = in_box_q && (rom_color != TRANS_KEY);
    end

`ifdef COIN_FLASH_EN
    assign shade = ((state == COLLECT) && tick_count[0]) ? ~rom_color : rom_color;
`else
    assign shade = rom_color;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            divider        <= '0;
            tick_count     <= '0;
            rise           <= '0;
            in_box_q       <= 1'b0;
            read_address   <= '0;
            frame_sel      <= '0;
            pixel_color    <= '0;
            pixel_valid    <= 1'b0;
            busy           <= 1'b0;
            collected_done <= 1'b0;
        end else begin
            collected_done <= 1'b0;
            read_address   <= addr_next;
            in_box_q       <= in_box;
            pixel_valid    <= opaque;
            pixel_color    <= opaque ? shade : 24'd0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SPIN;
                        busy       <= 1'b1;
                        frame_sel  <= '0;
                        divider    <= '0;
                        tick_count <= '0;
                        rise       <= '0;
                    end
                end
                SPIN: begin
                    if (collect) begin
                        state      <= COLLECT;
                        rise       <= '0;
                        tick_count <= '0;
                    end else if (frame_tick) begin
                        if (divider == DIV_LAST) begin
                            divider   <= '0;
                            frame_sel <= frame_sel + 2'd1;
                        end else begin
                            divider <= divider + 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (frame_tick) begin
                        frame_sel <= frame_sel + 2'd1;
                        if (tick_count == CNT_LAST) begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            collected_done <= 1'b1;
                            rise           <= '0;
                            tick_count     <= '0;
                        end else begin
                            tick_count <= tick_count + 1'b1;
                            rise       <= rise + 10'(RISE_STEP);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Leaving the animation flushes the pipeline so nothing leaks into IDLE.
            if (finishing) begin
                read_address <= '0;
                in_box_q     <= 1'b0;
                pixel_valid  <= 1'b0;
                pixel_color  <= '0;
            end
        end
    end

endmodule
